// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with a valid/ready handshake on both sides; shifts run one bit per cycle.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter instead (no SHIFT state, no counter).
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// SHIFT | iterative shift in progress, one bit per cycle
// HOLD  | out_valid=1, result held until out_ready
module alu_seq_exec #(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     sel,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  result,
  output logic           zero,
  output logic           ovf,
  output logic           illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DW-1:0] r_result;
  logic          r_zero;
  logic          r_ovf;
  logic          r_illegal;

  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_ovf;
  logic          w_alu_ill;
  logic          w_is_shift;
  logic          w_accept;

  assign w_sum      = a + b;
  assign w_diff     = a - b;
  assign w_is_shift = (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
  assign w_accept   = in_valid && (r_state == ST_IDLE);

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (sel)
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[DW-1] == b[DW-1]) && (w_sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[DW-1] != b[DW-1]) && (w_diff[DW-1] != a[DW-1]);
      end
      OP_SLT: w_alu_res = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: w_alu_res = b << shamt;
      OP_SRL: w_alu_res = b >> shamt;
      OP_SRA: w_alu_res = DW'($signed(b) >>> shamt);
`else
      // Iterative shifts are loaded from b directly; the ALU path is unused for them.
      OP_SLL, OP_SRL, OP_SRA: w_alu_res = b;
`endif
      OP_XOR: w_alu_res = a ^ b;
      OP_NOR: w_alu_res = ~(a | b);
      OP_NOP: w_alu_res = '0;
      default: w_alu_ill = 1'b1;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [SHW-1:0] r_cnt;
  logic [1:0]     r_shop;
  logic [DW-1:0]  w_step;

  always_comb begin
    w_step = r_result;
    case (r_shop)
      2'b01:   w_step = {r_result[DW-2:0], 1'b0};
      2'b10:   w_step = {1'b0, r_result[DW-1:1]};
      2'b11:   w_step = {r_result[DW-1], r_result[DW-1:1]};
      default: w_step = r_result;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
`ifdef ALU_FAST_SHIFT_EN
          w_state_next = ST_HOLD;
`else
          if (w_is_shift && (shamt != '0)) w_state_next = ST_SHIFT;
          else                             w_state_next = ST_HOLD;
`endif
        end
      end
      ST_SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
        if (r_cnt <= SHW'(1)) w_state_next = ST_HOLD;
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      r_cnt     <= '0;
      r_shop    <= 2'b00;
`endif
    end else begin
      if (w_accept) begin
        r_result  <= w_alu_res;
        r_zero    <= (w_alu_res == '0);
        r_ovf     <= w_alu_ovf;
        r_illegal <= w_alu_ill;
`ifndef ALU_FAST_SHIFT_EN
        if (w_is_shift) begin
          r_cnt  <= shamt;
          r_shop <= sel[1:0];
        end
`endif
      end
`ifndef ALU_FAST_SHIFT_EN
      else if (r_state == ST_SHIFT) begin
        r_result <= w_step;
        r_zero   <= (w_step == '0);
        r_cnt    <= r_cnt - SHW'(1);
      end
`endif
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign ovf     = r_ovf;
  assign illegal = r_illegal;

endmodule
